// File: rtl/bitonic_sort_dec_seq_pkg.sv
// Shared types and the compare-exchange schedule for the sequential descending bitonic sorter.
package sort_pkg;

   typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

   localparam int unsigned N        = 4;
   localparam int unsigned NumSteps = 6;

   typedef logic [1:0] slot_t;
   typedef logic [2:0] step_t;

   // Steps 0-1 build a bitonic sequence, steps 2-5 merge it largest-first.
   localparam slot_t CasI    [NumSteps] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
   localparam slot_t CasJ    [NumSteps] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3};
   localparam logic  CasDesc [NumSteps] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   localparam step_t LastStep = 3'd5;
   localparam slot_t LastSlot = 2'd3;

endpackage

// File: rtl/bitonic_sort_dec_seq_if.sv
// Streaming input/output bundle of the sorter; master drives words in and accepts results.
interface bitonic_sort_dec_seq_if #(
   parameter int unsigned W = 3
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/bitonic_sort_dec_seq_cas.sv
// Combinational compare-exchange: lo_slot goes back to index i, hi_slot to index j.
module sort_cas_unit #(
   parameter int unsigned W = 3
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         dir,
   output logic [W-1:0] lo_slot,
   output logic [W-1:0] hi_slot,
   output logic         swap
);

   // dir = 1 keeps the larger word at i; equal words never move.
   always_comb begin
      swap    = dir ? (a < b) : (a > b);
      lo_slot = swap ? b : a;
      hi_slot = swap ? a : b;
   end

endmodule

// File: rtl/bitonic_sort_dec_seq.sv
// Sequential 4-word descending bitonic sorter: serial load, six time-shared CAS steps, serial drain.
module bitonic_sort_dec_seq
   import sort_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input logic                  clk,
   input logic                  rst_n,
   bitonic_sort_dec_seq_if.slave bus
);

   state_e       state_q, state_d;
   slot_t        idx_q, idx_d;
   step_t        step_q, step_d;
   logic [W-1:0] words_q [N];
   logic [W-1:0] words_d [N];

   logic         in_fire, out_fire;
   slot_t        cas_i, cas_j;
   logic         cas_dir;
   logic [W-1:0] cas_lo, cas_hi;
   logic         cas_swap;

   assign in_fire  = bus.in_valid  & (state_q == StLoad);
   assign out_fire = bus.out_ready & (state_q == StDrain);

   assign cas_i   = CasI[step_q];
   assign cas_j   = CasJ[step_q];
   assign cas_dir = CasDesc[step_q];

   sort_cas_unit #(
      .W (W)
   ) u_cas (
      .a       (words_q[cas_i]),
      .b       (words_q[cas_j]),
      .dir     (cas_dir),
      .lo_slot (cas_lo),
      .hi_slot (cas_hi),
      .swap    (cas_swap)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:  if (in_fire && idx_q == LastSlot) state_d = StSort;
         StSort:  if (step_q == LastStep) state_d = StDrain;
         StDrain: if (out_fire && idx_q == LastSlot) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   // Output decode, purely from registered state
   always_comb begin
      bus.in_ready  = (state_q == StLoad);
      bus.out_valid = (state_q == StDrain);
      bus.busy      = (state_q != StLoad);
      bus.out_data  = (state_q == StDrain) ? words_q[idx_q] : '0;
      bus.out_last  = (state_q == StDrain) && (idx_q == LastSlot);
   end

   // Datapath next state; idx wraps to 0 naturally after slot 3.
   always_comb begin
      idx_d   = idx_q;
      step_d  = step_q;
      words_d = words_q;
      unique case (state_q)
         StLoad: begin
            step_d = '0;
            if (in_fire) begin
               words_d[idx_q] = bus.in_data;
               idx_d          = idx_q + 2'd1;
            end
         end
         StSort: begin
            idx_d = '0;
            if (cas_swap) begin
               words_d[cas_i] = cas_lo;
               words_d[cas_j] = cas_hi;
            end
            step_d = (step_q == LastStep) ? 3'd0 : step_q + 3'd1;
         end
         StDrain: begin
            if (out_fire) idx_d = idx_q + 2'd1;
         end
         default: begin
            idx_d  = '0;
            step_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         step_q <= '0;
         for (int unsigned k = 0; k < N; k++) words_q[k] <= '0;
      end else begin
         idx_q   <= idx_d;
         step_q  <= step_d;
         words_q <= words_d;
      end
   end

endmodule

// File: tb/tb_bitonic_sort_dec_seq.sv
// Directed table-driven bench for bitonic_sort_dec_seq with W = 3.
module tb_bitonic_sort_dec_seq;

   localparam int unsigned W = 3;

   typedef struct packed {
      logic [3:0][W-1:0] din;
      logic [3:0][W-1:0] dout;
      logic              gaps;
      logic [2:0]        stall_k;
      logic              timed;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   vec_t tbl [6];

   bitonic_sort_dec_seq_if #(.W(W)) bus ();

   bitonic_sort_dec_seq #(
      .W (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                               input int e0, input int e1, input int e2, input int e3,
                               input bit gaps, input int stall_k, input bit timed);
      vec_t v;
      v.din[0]  = W'(a0);
      v.din[1]  = W'(a1);
      v.din[2]  = W'(a2);
      v.din[3]  = W'(a3);
      v.dout[0] = W'(e0);
      v.dout[1] = W'(e1);
      v.dout[2] = W'(e2);
      v.dout[3] = W'(e3);
      v.gaps    = gaps;
      v.stall_k = 3'(stall_k);
      v.timed   = timed;
      return v;
   endfunction

   // Called at a negedge; returns at the negedge after the last output is accepted.
   task automatic run_group(input vec_t v);
      int   k;
      int   waitc;
      int   lat;
      time  t0;
      t0    = $time;
      k     = 0;
      waitc = 0;
      while (k < 4 && waitc < 100) begin
         check("load_in_ready", int'(bus.in_ready), 1);
         if (v.gaps && (waitc % 2 == 1)) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 3'd7;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = v.din[k];
            k++;
         end
         waitc++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         check("sort_in_ready", int'(bus.in_ready), 0);
         check("sort_busy", int'(bus.busy), 1);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 7);
      check("first_out_valid", int'(bus.out_valid), 1);
      for (int d = 0; d < 4; d++) begin
         if (d == int'(v.stall_k)) begin
            bus.out_ready = 1'b0;
            repeat (5) begin
               check("stall_valid", int'(bus.out_valid), 1);
               check("stall_data", int'(bus.out_data), int'(v.dout[d]));
               check("stall_last", int'(bus.out_last), (d == 3) ? 1 : 0);
               @(negedge clk);
            end
            bus.out_ready = 1'b1;
         end
         check("drain_valid", int'(bus.out_valid), 1);
         check("drain_data", int'(bus.out_data), int'(v.dout[d]));
         check("drain_last", int'(bus.out_last), (d == 3) ? 1 : 0);
         check("drain_in_ready", int'(bus.in_ready), 0);
         @(negedge clk);
      end
      check("post_in_ready", int'(bus.in_ready), 1);
      check("post_out_valid", int'(bus.out_valid), 0);
      check("post_busy", int'(bus.busy), 0);
      if (v.timed) check("group_cycles", int'(($time - t0) / 10), 14);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, int'(bus.in_ready), 1);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_last"}, int'(bus.out_last), 0);
      check({tag, "_out_data"}, int'(bus.out_data), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      tbl[0] = mk(1, 5, 2, 7, 7, 5, 2, 1, 1'b0, 4, 1'b1);
      tbl[1] = mk(3, 3, 0, 3, 3, 3, 3, 0, 1'b0, 4, 1'b1);
      tbl[2] = mk(0, 1, 2, 3, 3, 2, 1, 0, 1'b0, 4, 1'b1);
      tbl[3] = mk(7, 6, 5, 4, 7, 6, 5, 4, 1'b0, 4, 1'b1);
      tbl[4] = mk(5, 1, 6, 6, 6, 6, 5, 1, 1'b0, 1, 1'b0);
      tbl[5] = mk(4, 0, 6, 2, 6, 4, 2, 0, 1'b1, 4, 1'b0);

      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) run_group(tbl[t]);

      // Abort a group during SORT step 3, then confirm a clean restart.
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 3'(6 - k);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", int'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      run_group(mk(2, 7, 1, 1, 7, 2, 1, 1, 1'b0, 4, 1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bitonic_sort_dec_seq.md
# bitonic_sort_dec_seq

Sequential, descending-order 4-element bitonic sorter with streaming valid/ready input and output. It accepts four W-bit words serially, sorts them largest-first with a single time-shared compare-exchange unit, then drains them serially. It is the multi-cycle, opposite-direction counterpart of the increasing combinational sorting-network slices. It sits between a word producer and any consumer that needs a ranked 4-word group without the area of a full parallel network.

## Interface
- W, 3, data word width in bits (W >= 1); group size N = 4 is fixed
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block accepts a word this cycle
- in_data  input  W  unsigned input word
- out_valid  output  1  out_data holds a sorted word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  W  sorted word, largest first
- out_last  output  1  marks the 4th (smallest) word of a group
- busy  output  1  high in SORT or DRAIN

## Operation
- Storage: four W-bit registers buf[0..3]. Index counter idx (2 bits). Step counter step (3 bits, 0..5).
- FSM states: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: buf[idx] <= in_data and idx++.
  - When the 4th word is accepted (idx == 3): go to SORT, with idx <= 0 and step <= 0.
- SORT:
  - One compare-exchange per cycle, selected by step. CAS(i,j) with direction d:
    - desc: swap if buf[i] < buf[j].
    - asc: swap if buf[i] > buf[j].
    - Equal values are never swapped.
  - Step schedule:
    - 0: CAS(0,1) desc
    - 1: CAS(2,3) asc
    - 2: CAS(0,2) desc
    - 3: CAS(1,3) desc
    - 4: CAS(0,1) desc
    - 5: CAS(2,3) desc
  - After step 5: go to DRAIN.
- DRAIN:
  - out_valid = 1, out_data = buf[idx], out_last = (idx == 3).
  - On out_valid & out_ready: idx++.
  - After the last word is accepted: go to LOAD with idx <= 0.
- Comparisons are unsigned over the full W bits. No arithmetic widening is needed.
- in_ready, out_valid, out_data, out_last and busy are decoded from registered state; there are no combinational paths from in_valid or out_ready to any output.

## Timing
- Reset (rst_n low, asynchronous):
  - State = LOAD, idx = 0, step = 0, buf = 0.
  - out_valid = 0, out_last = 0, out_data = 0, busy = 0.
  - in_ready reads 1, but no transfer is accepted while rst_n is low.
- Throughput per group: 4 load cycles (minimum) + 6 sort cycles + 4 drain cycles (minimum) = 14 cycles.
- Latency: first output is valid 7 cycles after the cycle in which the 4th input is accepted (6 SORT cycles, then DRAIN).
- in_ready is 0 throughout SORT and DRAIN. Input backpressure is the producer's concern.
- Output stalls: out_valid stays high and out_data/out_last stay stable while out_ready = 0.
- Input gaps: in_valid low in LOAD holds idx. Partial groups wait indefinitely.
- Group boundary: the cycle after the last word is accepted (out_last & out_ready), the block is in LOAD with in_ready = 1. There is no overlap of drain and load.
- Reset mid-operation: everything is discarded immediately and the block restarts in LOAD with idx = 0.

## Structure
- Shared package (sort_pkg) holds:
  - state enum {LOAD, SORT, DRAIN}
  - localparam N = 4
  - the step-to-(i, j, dir) schedule as constant arrays
- One natural sub-module: sort_cas_unit.
  - Combinational.
  - Inputs: a, b (W bits each), dir.
  - Outputs: lo_slot, hi_slot words and a swap flag.
  - Instantiated once and muxed over buf by step.

## Test plan
- Reset, then load 1,5,2,7 with out_ready = 1 → out_data 7,5,2,1; out_last only on 1; first out_valid 7 cycles after the 4th accept.
- W = 3, load 3,3,0,3 → 3,3,3,0; equal values produce no spurious change and the group completes in exactly 14 cycles.
- Already-ascending 0,1,2,3, then already-descending 7,6,5,4 back-to-back → 3,2,1,0 then 7,6,5,4; in_ready is low from the 4th accept until the cycle after out_last is accepted.
- Hold out_ready = 0 for 5 cycles on the 2nd output word → out_data stays stable at that value, out_valid stays 1, idx does not advance.
- Toggle in_valid every other cycle while loading 4,0,6,2 → only valid cycles are captured; output is 6,4,2,0.
- Assert rst_n low during SORT step 3 → all outputs return to their reset values asynchronously; the next group 2,7,1,1 sorts to 7,2,1,1.
